fsm_ab_tx: RTL and testbench

Serial frame transmitter that produces the bitstream consumed by the lab's "101" sequence-detector FSM. It accepts a parallel word over a valid/ready handshake and emits, one bit per clock, a sync preamble 1,0,1 followed by the word MSB-first, then a guard bit. A downstream detector sees the preamble as a frame marker. The block serves as both a stimulus source and the transmit end of the serial link.

---
 rtl/fsm_ab_tx.sv | 103 ++++++++++
 tb/tb_fsm_ab_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_ab_tx.sv
// Serial frame transmitter: preamble 1,0,1, then the word MSB-first, then a guard 0 with done.
// All outputs are registers loaded with the value for the state being entered.
module fsm_ab_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             serial_out,
    output logic             done,
    output logic [1:0]       state_out
);

    localparam int CNT_W = $clog2((WIDTH > 3) ? WIDTH : 3);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        DATA = 2'b10,
        GAP  = 2'b11
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_serial;
    logic               r_ready;
    logic               r_done;
    logic [WIDTH-1:0]   w_shreg_shl;

    // Written as a shift so WIDTH = 1 needs no special-case slice.
    assign w_shreg_shl = r_shreg << 1'b1;

    assign ready_out  = r_ready;
    assign serial_out = r_serial;
    assign done       = r_done;
    assign state_out  = r_state;

    // Frame sequencer; each transition also loads the outputs of the destination state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_shreg  <= {WIDTH{1'b0}};
            r_serial <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_in && r_ready) begin
                        r_shreg  <= data_in;
                        r_cnt    <= {CNT_W{1'b0}};
                        r_state  <= SYNC;
                        r_serial <= 1'b1;
                        r_ready  <= 1'b0;
                    end else begin
                        r_serial <= 1'b0;
                        r_ready  <= 1'b1;
                    end
                end
                SYNC: begin
                    if (r_cnt == CNT_W'(2)) begin
                        r_cnt    <= {CNT_W{1'b0}};
                        r_state  <= DATA;
                        r_serial <= r_shreg[WIDTH-1];
                    end else begin
                        // Next preamble bit is (next cnt != 1): 0 after cnt 0, 1 after cnt 1.
                        r_cnt    <= r_cnt + CNT_W'(1);
                        r_serial <= (r_cnt != {CNT_W{1'b0}});
                    end
                end
                DATA: begin
                    r_shreg <= w_shreg_shl;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state  <= GAP;
                        r_serial <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_serial <= w_shreg_shl[WIDTH-1];
                    end
                end
                GAP: begin
                    r_state  <= IDLE;
                    r_serial <= 1'b0;
                    r_done   <= 1'b0;
                    r_ready  <= 1'b1;
                end
                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= {CNT_W{1'b0}};
                    r_serial <= 1'b0;
                    r_done   <= 1'b0;
                    r_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_ab_tx.sv
// Directed bench for fsm_ab_tx: WIDTH=8 main instance plus a WIDTH=1 instance for the edge case.
module tb_fsm_ab_tx;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       serial_out;
    logic       done;
    logic [1:0] state_out;

    logic [0:0] d1;
    logic       v1;
    logic       r1;
    logic       s1;
    logic       dn1;
    logic [1:0] st1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e1;
    int e2;
    int npulse;
    logic [2:0] hist;
    logic       det;

    fsm_ab_tx #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .serial_out (serial_out),
        .done       (done),
        .state_out  (state_out)
    );

    fsm_ab_tx #(.WIDTH(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .data_in    (d1),
        .valid_in   (v1),
        .ready_out  (r1),
        .serial_out (s1),
        .done       (dn1),
        .state_out  (st1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference "101" detector fed from the serial line.
    always @(posedge clock) begin
        if (reset) hist <= 3'b000;
        else       hist <= {hist[1:0], serial_out};
    end
    assign det = (hist == 3'b101);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one WIDTH=8 frame, starting just after the accept edge.
    // mode 0: drop valid; 1: leave valid as is; 2: scramble valid/data while busy.
    task automatic frame8(input logic [7:0] d, input int mode);
        logic [11:0] exp;
        logic [1:0]  st;
        exp = {3'b101, d, 1'b0};
        for (int k = 0; k < 12; k++) begin
            st = (k < 3) ? 2'b01 : ((k < 11) ? 2'b10 : 2'b11);
            check("frame_serial", serial_out, exp[11-k]);
            check("frame_done", done, (k == 11));
            check("frame_ready", ready_out, 0);
            check("frame_state", state_out, st);
            if (mode == 2 && k < 11) begin
                valid_in = 1'($urandom_range(0, 1));
                data_in  = 8'($urandom);
            end else if (mode != 1) begin
                valid_in = 1'b0;
            end
            tick();
        end
        check("post_ready", ready_out, 1);
        check("post_state", state_out, 0);
        check("post_serial", serial_out, 0);
        check("post_done", done, 0);
    endtask

    task automatic frame1(input logic dbit);
        logic [4:0] exp;
        logic [1:0] st;
        exp = {3'b101, dbit, 1'b0};
        for (int k = 0; k < 5; k++) begin
            st = (k < 3) ? 2'b01 : ((k < 4) ? 2'b10 : 2'b11);
            check("w1_serial", s1, exp[4-k]);
            check("w1_done", dn1, (k == 4));
            check("w1_state", st1, st);
            v1 = 1'b0;
            tick();
        end
        check("w1_ready", r1, 1);
        check("w1_idle", st1, 0);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'hA5;
        v1       = 1'b0;
        d1       = 1'b0;

        // Reset held two cycles with valid high: nothing is accepted.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_serial", serial_out, 0);
            check("rst_ready", ready_out, 1);
            check("rst_done", done, 0);
            check("rst_state", state_out, 0);
        end
        reset    = 1'b0;
        valid_in = 1'b0;
        tick();
        check("idle_state", state_out, 0);
        check("idle_ready", ready_out, 1);

        // Single frame 0xA5.
        valid_in = 1'b1;
        data_in  = 8'hA5;
        tick();
        frame8(8'hA5, 0);

        // Busy input and data stability.
        valid_in = 1'b1;
        data_in  = 8'hC3;
        tick();
        frame8(8'hC3, 2);

        // Back-to-back with valid held: 0xFF then 0x00.
        valid_in = 1'b1;
        data_in  = 8'hFF;
        tick();
        e1 = cyc;
        data_in = 8'h00;
        frame8(8'hFF, 1);
        tick();
        e2 = cyc;
        check("b2b_period", e2 - e1, 13);
        frame8(8'h00, 0);

        // Mid-frame reset at E+6.
        valid_in = 1'b1;
        data_in  = 8'h3C;
        tick();
        valid_in = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_serial", serial_out, 0);
        check("mrst_state", state_out, 0);
        check("mrst_done", done, 0);
        check("mrst_ready", ready_out, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_nodone", done, 0);
            check("mrst_line", serial_out, 0);
        end
        valid_in = 1'b1;
        data_in  = 8'h96;
        tick();
        frame8(8'h96, 0);

        // Loopback into the detector with 0x00.
        valid_in = 1'b1;
        data_in  = 8'h00;
        tick();
        valid_in = 1'b0;
        npulse   = 0;
        for (int k = 0; k < 15; k++) begin
            check("det_timing", det, (k == 3));
            if (det) npulse++;
            tick();
        end
        check("det_pulses", npulse, 1);

        // WIDTH = 1 instance.
        v1 = 1'b1;
        d1 = 1'b1;
        tick();
        frame1(1'b1);
        v1 = 1'b1;
        d1 = 1'b0;
        tick();
        frame1(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
